// File: rtl/vec3_op_if.sv
// Request/response handshake bundle for the vec3 op sequencer.
// The master issues ops and consumes results; the slave is the sequencer.
interface vec3_op_if #(
  parameter int WORD_WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_op;
  logic [3*WORD_WIDTH-1:0] in_a;
  logic [3*WORD_WIDTH-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [3*WORD_WIDTH-1:0] out_res;
  logic [1:0]              out_op;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_op
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_op
  );
endinterface

// File: rtl/vec3_op_sequencer.sv
// Time-multiplexes one pipelined fixed-point multiplier across
// vec3 DOT/CROSS/SCALE/ADD ops, one op in flight at a time.
module vec3_op_sequencer #(
  parameter int WORD_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int MUL_LAT    = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  vec3_op_if.slave             io,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] ops_done
);
  localparam int W = WORD_WIDTH;
  localparam logic [1:0] OP_DOT   = 2'd0;
  localparam logic [1:0] OP_CROSS = 2'd1;
  localparam logic [1:0] OP_SCALE = 2'd2;
  localparam logic [1:0] OP_ADD   = 2'd3;

  typedef enum logic [2:0] {
    IDLE, ISSUE, DRAIN, ADDC, DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]       op_q;
  logic [W-1:0]     ax, ay, az, bx, by, bz;
  logic [2:0]       iidx, cidx, nprod;
  logic [W-1:0]     prod [8];
  logic [W-1:0]     pd [MUL_LAT];
  logic [MUL_LAT-1:0] pv;
  logic [W-1:0]     ma, mb, mq;
  logic signed [2*W-1:0] mfull;
  logic [3*W-1:0]   res_q, res_nx;
  logic [1:0]       rop_q;
  logic             accept, out_hs, combine;

  assign accept  = io.in_valid && io.in_ready;
  assign out_hs  = io.out_valid && io.out_ready;
  assign nprod   = (op_q == OP_CROSS) ? 3'd6 : 3'd3;
  assign combine = (state == ADDC) ||
                   (state == DRAIN && cidx == nprod);

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.out_res   = res_q;
  assign io.out_op    = rop_q;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = (io.in_op == OP_ADD) ? ADDC : ISSUE;
      ISSUE:
        if (iidx == nprod - 3'd1) state_nx = DRAIN;
      DRAIN:
        if (combine) state_nx = DONE;
      ADDC:
        state_nx = DONE;
      DONE:
        if (io.out_ready) state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // SCALE reuses bx as the scalar, so only CROSS needs its own order.
  always_comb begin
    ma = '0;
    mb = '0;
    if (op_q == OP_CROSS) begin
      unique case (iidx)
        3'd0:    begin ma = ay; mb = bz; end
        3'd1:    begin ma = az; mb = by; end
        3'd2:    begin ma = az; mb = bx; end
        3'd3:    begin ma = ax; mb = bz; end
        3'd4:    begin ma = ax; mb = by; end
        default: begin ma = ay; mb = bx; end
      endcase
    end else begin
      unique case (iidx)
        3'd0:    begin ma = ax; mb = bx; end
        3'd1:    begin ma = ay; mb = (op_q == OP_SCALE) ? bx : by; end
        default: begin ma = az; mb = (op_q == OP_SCALE) ? bx : bz; end
      endcase
    end
  end

  assign mfull = $signed(ma) * $signed(mb);
  assign mq    = mfull[FRAC_BITS +: W];

  always_comb begin
    res_nx = '0;
    unique case (op_q)
      OP_DOT:   res_nx = {prod[0] + prod[1] + prod[2], {W{1'b0}}, {W{1'b0}}};
      OP_CROSS: res_nx = {prod[0] - prod[1], prod[2] - prod[3],
                          prod[4] - prod[5]};
      OP_SCALE: res_nx = {prod[0], prod[1], prod[2]};
      default:  res_nx = {ax + bx, ay + by, az + bz};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv       <= '0;
      iidx     <= '0;
      cidx     <= '0;
      op_q     <= '0;
      res_q    <= '0;
      rop_q    <= '0;
      ops_done <= '0;
    end else begin
      pv[0] <= (state == ISSUE);
      pd[0] <= mq;
      for (int i = 1; i < MUL_LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
      if (accept) begin
        op_q <= io.in_op;
        {ax, ay, az} <= io.in_a;
        {bx, by, bz} <= io.in_b;
        iidx <= '0;
        cidx <= '0;
      end
      if (state == ISSUE) iidx <= iidx + 3'd1;
      if (pv[MUL_LAT-1]) begin
        prod[cidx] <= pd[MUL_LAT-1];
        cidx       <= cidx + 3'd1;
      end
      if (combine) begin
        res_q <= res_nx;
        rop_q <= op_q;
      end
      if (out_hs) ops_done <= ops_done + 1'b1;
    end
  end
endmodule

// File: tb/tb_vec3_op_sequencer.sv
// Directed bench for vec3_op_sequencer with an arithmetic reference
// model and a per-cycle output monitor.
module tb_vec3_op_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [15:0] ops_done;

  always #5 clk = ~clk;

  vec3_op_if #(.WORD_WIDTH(32)) io ();

  vec3_op_sequencer #(
    .WORD_WIDTH(32), .FRAC_BITS(16), .MUL_LAT(2), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .io(io), .busy(busy), .ops_done(ops_done)
  );

  int pass_cnt = 0;
  int tot = 0;
  logic [95:0] exp_res;
  logic [1:0]  exp_op;
  bit          exp_live = 0;
  logic [15:0] tb_done = 0;

  task automatic check(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
    tot++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 32'(p >>> 16);
  endfunction

  function automatic logic [95:0] model(input logic [1:0] op,
                                        input logic [95:0] a,
                                        input logic [95:0] b);
    logic [31:0] x1, y1, z1, x2, y2, z2;
    {x1, y1, z1} = a;
    {x2, y2, z2} = b;
    case (op)
      2'd0: return {fmul(x1, x2) + fmul(y1, y2) + fmul(z1, z2), 64'd0};
      2'd1: return {fmul(y1, z2) - fmul(z1, y2),
                    fmul(z1, x2) - fmul(x1, z2),
                    fmul(x1, y2) - fmul(y1, x2)};
      2'd2: return {fmul(x1, x2), fmul(y1, x2), fmul(z1, x2)};
      default: return {x1 + x2, y1 + y2, z1 + z2};
    endcase
  endfunction

  function automatic int lat(input logic [1:0] op);
    if (op == 2'd3) return 1;
    return ((op == 2'd1) ? 6 : 3) + 2 + 1;
  endfunction

  function automatic logic [95:0] v(input logic [31:0] x,
                                    input logic [31:0] y,
                                    input logic [31:0] z);
    return {x, y, z};
  endfunction

  always @(negedge clk) begin
    if (!rst && io.out_valid) begin
      check("mon_live", 96'(exp_live), 96'd1);
      check("mon_res", io.out_res, exp_res);
      check("mon_op", 96'(io.out_op), 96'(exp_op));
    end
  end

  task automatic issue(input logic [1:0] op, input logic [95:0] a,
                       input logic [95:0] b);
    @(negedge clk);
    io.in_valid = 1'b1;
    io.in_op    = op;
    io.in_a     = a;
    io.in_b     = b;
    check("in_ready_idle", 96'(io.in_ready), 96'd1);
    @(posedge clk);
    exp_res  = model(op, a, b);
    exp_op   = op;
    exp_live = 1'b1;
    #1;
    io.in_valid = 1'b0;
    io.in_a     = '1;
    io.in_b     = ~b;
  endtask

  task automatic run(input string name, input logic [1:0] op,
                     input logic [95:0] a, input logic [95:0] b,
                     input logic [95:0] lit);
    int cyc;
    bit seen;
    issue(op, a, b);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 30) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (io.out_valid) seen = 1;
    end
    check({name, "_lat"}, 96'(cyc), 96'(lat(op)));
    check({name, "_lit"}, io.out_res, lit);
  endtask

  task automatic consume(input string name);
    io.out_ready = 1'b1;
    @(posedge clk);
    exp_live = 1'b0;
    tb_done++;
    #1 io.out_ready = 1'b0;
    io.in_valid = 1'b0;
    @(negedge clk);
    check({name, "_rdy_after"}, 96'(io.in_ready), 96'd1);
    check({name, "_ovalid_after"}, 96'(io.out_valid), 96'd0);
    check({name, "_ops_done"}, 96'(ops_done), 96'(tb_done));
  endtask

  localparam logic [31:0] ONE = 32'h0001_0000;
  logic [95:0] held;

  initial begin
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.in_op     = 2'd0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 96'(io.in_ready), 96'd1);
    check("rst_out_valid", 96'(io.out_valid), 96'd0);
    check("rst_out_res", io.out_res, 96'd0);
    check("rst_out_op", 96'(io.out_op), 96'd0);
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_ops_done", 96'(ops_done), 96'd0);
    rst = 1'b0;

    run("dot1", 2'd0, v(ONE, 2*ONE, 3*ONE), v(4*ONE, 5*ONE, 6*ONE),
        v(32'h0020_0000, 0, 0));
    consume("dot1");

    run("cross_xy", 2'd1, v(ONE, 0, 0), v(0, ONE, 0), v(0, 0, ONE));
    consume("cross_xy");
    run("cross_yx", 2'd1, v(0, ONE, 0), v(ONE, 0, 0),
        v(0, 0, 32'hFFFF_0000));
    consume("cross_yx");

    run("scale", 2'd2, v(32'h0001_8000, 32'hFFFE_0000, 32'h0000_4000),
        v(32'hFFFE_0000, 32'h1234_5678, 32'h0BAD_0000),
        v(32'hFFFD_0000, 32'h0004_0000, 32'hFFFF_8000));
    consume("scale");

    run("dot_bp", 2'd0, v(ONE, 2*ONE, 3*ONE), v(4*ONE, 5*ONE, 6*ONE),
        v(32'h0020_0000, 0, 0));
    held = io.out_res;
    io.in_valid = 1'b1;
    io.in_op    = 2'd3;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 96'(io.in_ready), 96'd0);
      check("bp_hold", io.out_res, held);
      check("bp_busy", 96'(busy), 96'd1);
    end
    consume("dot_bp");

    run("add_wrap", 2'd3, v(32'h7FFF_FFFF, ONE, 0), v(32'h0000_0001, ONE, 0),
        v(32'h8000_0000, 32'h0002_0000, 0));
    consume("add_wrap");
    run("scale_wrap", 2'd2, v(32'h0100_0000, 0, 0), v(32'h0100_0000, 0, 0),
        v(0, 0, 0));
    consume("scale_wrap");

    issue(2'd1, v(ONE, 0, 0), v(0, ONE, 0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_live = 1'b0;
    tb_done  = '0;
    @(negedge clk);
    check("mrst_in_ready", 96'(io.in_ready), 96'd1);
    check("mrst_out_valid", 96'(io.out_valid), 96'd0);
    check("mrst_ops_done", 96'(ops_done), 96'd0);
    repeat (12) @(negedge clk);
    check("mrst_no_stale", 96'(io.out_valid), 96'd0);

    run("dot_after_rst", 2'd0, v(ONE, 2*ONE, 3*ONE), v(4*ONE, 5*ONE, 6*ONE),
        v(32'h0020_0000, 0, 0));
    consume("dot_after_rst");

    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
